// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared encodings for the unified-memory arbiter.
//   SZ_WORD/SZ_HALF/SZ_BYTE : load/store size select, same encoding as the core's LSU
//   state_e                 : arbiter FSM states
//   grant_e                 : requester identity for round-robin tie breaking
//   is_misaligned()         : alignment/legality check for a data access
package mem_arbiter_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMemI = 2'd1,
        StMemD = 2'd2,
        StResp = 2'd3
    } state_e;

    typedef enum logic {
        GntI = 1'b0,
        GntD = 1'b1
    } grant_e;

    // Size 11 has no meaning and is reported as an error like a misalignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic r;
        case (size)
            SZ_WORD: r = (off != 2'b00);
            SZ_HALF: r = off[0];
            SZ_BYTE: r = 1'b0;
            default: r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane logic for the data path.
// Ports:
//   i_off        in  2   byte offset within the word (addr[1:0])
//   i_size       in  2   access size (SZ_WORD/SZ_HALF/SZ_BYTE)
//   i_signed     in  1   sign-extend sub-word loads
//   i_wdata      in  32  right-aligned store data
//   i_rdata      in  32  raw memory read word
//   o_be         out 4   byte enables
//   o_wdata      out 32  store data replicated onto every candidate lane
//   o_rdata      out 32  extracted and extended load data
//   o_misaligned out 1   misaligned or illegal-size access
module mem_lane_align
    import mem_arbiter_pkg::*;
(
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign o_misaligned = is_misaligned(i_size, i_off);

    always_comb begin
        w_byte  = i_rdata[{i_off, 3'b000} +: 8];
        w_half  = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
        case (i_size)
            SZ_BYTE: begin
                o_be    = 4'b0001 << i_off;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{i_signed & w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                o_be    = i_off[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {{16{i_signed & w_half[15]}}, w_half};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-ported unified memory between instruction fetch
// and the load/store path with round-robin tie breaking.
// Optional feature: define MEM_ARBITER_TIMEOUT_EN to abort memory cycles that see no
// mem_ready within TIMEOUT_CYCLES cycles.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_req/i_addr                fetch request (level) and word address
//   i_done/i_rdata              fetch completion pulse and fetched word
//   d_req/d_we/d_addr/d_size/
//   d_signed/d_wdata            data request (level) and access attributes
//   d_done/d_rdata/d_err        data completion pulse, extended load data, error flag
//   mem_req/mem_we/mem_addr/
//   mem_be/mem_wdata            registered memory port, held until mem_ready
//   mem_rdata/mem_ready         memory read data and cycle completion
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_done,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [1:0]  d_size,
    input  logic        d_signed,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_e      r_state;
    grant_e      r_last_grant;
    logic        r_i_done, r_d_done, r_d_err, r_mem_req, r_mem_we;
    logic [31:0] r_i_rdata, r_d_rdata, r_mem_addr, r_mem_wdata;
    logic [3:0]  r_mem_be;

    logic        w_grant_d, w_grant_i, w_misaligned, w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_rdata;
    logic        w_unused_i_addr;

    assign w_unused_i_addr = ^i_addr[1:0];

    // Requests are held until done, so the live d_* attributes are still valid when the
    // read data comes back and can drive the load extract directly.
    mem_lane_align u_lane_align (
        .i_off        (d_addr[1:0]),
        .i_size       (d_size),
        .i_signed     (d_signed),
        .i_wdata      (d_wdata),
        .i_rdata      (mem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_rdata      (w_rdata),
        .o_misaligned (w_misaligned)
    );

    // On a tie the requester not served last wins.
    assign w_grant_d = d_req && (!i_req || (r_last_grant == GntI));
    assign w_grant_i = i_req && !w_grant_d;

`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                   $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CntW-1:0] r_wait_cnt;

    // Fires on the TIMEOUT_CYCLES-th cycle spent in a memory state.
    assign w_timeout = ((r_wait_cnt + 1'b1) == CntW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if ((r_state == StMemI) || (r_state == StMemD)) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end else begin
            r_wait_cnt <= '0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_last_grant <= GntI;
            r_i_done     <= 1'b0;
            r_d_done     <= 1'b0;
            r_d_err      <= 1'b0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_be     <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_grant_d) begin
                        if (w_misaligned) begin
                            r_d_done  <= 1'b1;
                            r_d_err   <= 1'b1;
                            r_d_rdata <= '0;
                            r_state   <= StResp;
                        end else begin
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= d_we;
                            r_mem_addr  <= {d_addr[31:2], 2'b00};
                            r_mem_be    <= w_be;
                            r_mem_wdata <= w_wdata;
                            r_state     <= StMemD;
                        end
                    end else if (w_grant_i) begin
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= {i_addr[31:2], 2'b00};
                        r_mem_be   <= 4'b1111;
                        r_state    <= StMemI;
                    end
                end
                StMemI: begin
                    if (mem_ready || w_timeout) begin
                        r_mem_req <= 1'b0;
                        r_mem_be  <= '0;
                        r_i_rdata <= mem_ready ? mem_rdata : '0;
                        r_i_done  <= 1'b1;
                        r_state   <= StResp;
                    end
                end
                StMemD: begin
                    if (mem_ready || w_timeout) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_mem_be  <= '0;
                        r_d_err   <= !mem_ready;
                        r_d_rdata <= (mem_ready && !r_mem_we) ? w_rdata : '0;
                        r_d_done  <= 1'b1;
                        r_state   <= StResp;
                    end
                end
                StResp: begin
                    // Exactly one done is high here; it names the requester just served.
                    r_last_grant <= r_d_done ? GntD : GntI;
                    r_state      <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign i_done    = r_i_done;
    assign i_rdata   = r_i_rdata;
    assign d_done    = r_d_done;
    assign d_rdata   = r_d_rdata;
    assign d_err     = r_d_err;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;

endmodule
